adc_ch_arbiter: RTL

Merges the Simple Interface sample streams of the two adc_block channels (CH0, CH1) onto one write port toward the acquisition buffer.
- Per-channel one-entry holding slot; round-robin grant when both slots are pending.
- Output uses a ready/ack handshake; the producers have no backpressure, so drops are flagged as overflow.
- Channel enable, overflow clear and flush are set through the register Simple Interface bus.

---
 rtl/adc_ch_arbiter_pkg.sv | 16 +
 rtl/adc_ch_arbiter_slot.sv | 69 ++++++
 rtl/adc_ch_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adc_ch_arbiter_pkg.sv
// Shared constants for the ADC channel arbiter: CTRL register layout and output FSM states.
package adc_ch_arbiter_pkg;

  localparam int unsigned ADDR_ARB_CTRL_DEF = 3;

  localparam int unsigned CTRL_CH0_EN  = 0;
  localparam int unsigned CTRL_CH1_EN  = 1;
  localparam int unsigned CTRL_OVF_CLR = 2;
  localparam int unsigned CTRL_FLUSH   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/adc_ch_arbiter_slot.sv
// One-entry holding slot for a single ADC channel with sticky drop flag.
// Optional drop counter enabled by ADC_ARB_OVF_CNT_EN.
module adc_arb_slot #(
  parameter int unsigned BITS_ADC      = 8,
  parameter int unsigned OVF_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic [BITS_ADC-1:0]      si_data,
  input  logic                     si_rdy,
  input  logic                     en,
  input  logic                     dis,
  input  logic                     flush,
  input  logic                     drain,
  input  logic                     ovf_clr,
`ifdef ADC_ARB_OVF_CNT_EN
  output logic [OVF_CNT_WIDTH-1:0] ovf_cnt,
`endif
  output logic [BITS_ADC-1:0]      data,
  output logic                     valid,
  output logic                     ovf
);

  logic capture;
  logic accept;
  logic drop;

  // A same-edge drain or flush frees the slot, so the new sample takes it.
  always_comb begin
    capture = si_rdy && en && !dis;
    accept  = capture && (!valid || drain || flush);
    drop    = capture && valid && !drain && !flush;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (dis) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      data  <= si_data;
    end else if (drain || flush) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

`ifdef ADC_ARB_OVF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst)
      ovf_cnt <= '0;
    else if (ovf_clr)
      ovf_cnt <= drop ? OVF_CNT_WIDTH'(1) : '0;
    else if (drop && (ovf_cnt != '1))
      ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/adc_ch_arbiter.sv
// Merges the CH0/CH1 ADC sample streams onto one ready/ack write port with round-robin grant.
// Define ADC_ARB_OVF_CNT_EN to add per-channel saturating drop counters.
module adc_ch_arbiter
  import adc_ch_arbiter_pkg::*;
#(
  parameter int unsigned               BITS_ADC       = 8,
  parameter int unsigned               REG_DATA_WIDTH = 16,
  parameter int unsigned               REG_ADDR_WIDTH = 8,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_ARB_CTRL  = REG_ADDR_WIDTH'(ADDR_ARB_CTRL_DEF),
  parameter logic [1:0]                DEFAULT_CH_EN  = 2'b11,
  parameter int unsigned               OVF_CNT_WIDTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [BITS_ADC-1:0]       ch0_si_data,
  input  logic                      ch0_si_rdy,
  input  logic [BITS_ADC-1:0]       ch1_si_data,
  input  logic                      ch1_si_rdy,
  output logic [BITS_ADC-1:0]       out_data,
  output logic                      out_ch,
  output logic                      out_rdy,
  input  logic                      out_ack,
  output logic [1:0]                ovf_o,
`ifdef ADC_ARB_OVF_CNT_EN
  output logic [OVF_CNT_WIDTH-1:0]  ovf_cnt0_o,
  output logic [OVF_CNT_WIDTH-1:0]  ovf_cnt1_o,
`endif
  input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
  input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
  input  logic                      reg_si_rdy
);

  arb_state_t          state;
  logic [1:0]          en;
  logic                rr_last;
  logic                ctrl_wr;
  logic                ovf_clr;
  logic                flush;
  logic                dis0;
  logic                dis1;
  logic                v0;
  logic                v1;
  logic [BITS_ADC-1:0] d0;
  logic [BITS_ADC-1:0] d1;
  logic                can_load;
  logic                grant;
  logic                drain0;
  logic                drain1;
  logic                unused_reg_bits;

  assign unused_reg_bits = ^reg_si_data[REG_DATA_WIDTH-1:4];

  always_comb begin
    ctrl_wr = reg_si_rdy && (reg_si_addr == ADDR_ARB_CTRL);
    ovf_clr = ctrl_wr && reg_si_data[CTRL_OVF_CLR];
    flush   = ctrl_wr && reg_si_data[CTRL_FLUSH];
    dis0    = ctrl_wr && !reg_si_data[CTRL_CH0_EN];
    dis1    = ctrl_wr && !reg_si_data[CTRL_CH1_EN];
  end

  always_ff @(posedge clk_i) begin
    if (rst)
      en <= DEFAULT_CH_EN;
    else if (ctrl_wr)
      en <= {reg_si_data[CTRL_CH1_EN], reg_si_data[CTRL_CH0_EN]};
  end

  adc_arb_slot #(
    .BITS_ADC      (BITS_ADC),
    .OVF_CNT_WIDTH (OVF_CNT_WIDTH)
  ) u_slot0 (
    .clk_i   (clk_i),
    .rst     (rst),
    .si_data (ch0_si_data),
    .si_rdy  (ch0_si_rdy),
    .en      (en[0]),
    .dis     (dis0),
    .flush   (flush),
    .drain   (drain0),
    .ovf_clr (ovf_clr),
`ifdef ADC_ARB_OVF_CNT_EN
    .ovf_cnt (ovf_cnt0_o),
`endif
    .data    (d0),
    .valid   (v0),
    .ovf     (ovf_o[0])
  );

  adc_arb_slot #(
    .BITS_ADC      (BITS_ADC),
    .OVF_CNT_WIDTH (OVF_CNT_WIDTH)
  ) u_slot1 (
    .clk_i   (clk_i),
    .rst     (rst),
    .si_data (ch1_si_data),
    .si_rdy  (ch1_si_rdy),
    .en      (en[1]),
    .dis     (dis1),
    .flush   (flush),
    .drain   (drain1),
    .ovf_clr (ovf_clr),
`ifdef ADC_ARB_OVF_CNT_EN
    .ovf_cnt (ovf_cnt1_o),
`endif
    .data    (d1),
    .valid   (v1),
    .ovf     (ovf_o[1])
  );

`ifndef ADC_ARB_OVF_CNT_EN
  logic [OVF_CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

  // Both pending: grant the channel that did not win last time.
  always_comb begin
    can_load = ((state == ST_EMPTY) || out_ack) && (v0 || v1);
    grant    = (v0 && v1) ? !rr_last : v1;
    drain0   = can_load && !grant;
    drain1   = can_load && grant;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_ch   <= 1'b0;
      rr_last  <= 1'b1;
    end else if (can_load) begin
      state    <= ST_FULL;
      out_data <= grant ? d1 : d0;
      out_ch   <= grant;
      rr_last  <= grant;
    end else if ((state == ST_FULL) && out_ack) begin
      state    <= ST_EMPTY;
    end
  end

  assign out_rdy = (state == ST_FULL);

endmodule
